buffer_port_arbiter: RTL

Shares the single write port and single read port of one local scratch buffer between `numReq` requesters (PE lanes, bus interface, PU control) using independent round-robin arbitration per port. The block sits directly in front of a buffer instance and drives its `wrt`/`wrt_addr`/`data_in` and `rd_en`/`rd_addr` pins. It tags each granted read so the returned `data_out` word is flagged valid to the correct requester one cycle later.

---
 rtl/buffer_port_arbiter_pkg.sv | 16 +
 rtl/buffer_port_arbiter_rr.sv | 49 ++++
 rtl/buffer_port_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/buffer_port_arbiter_pkg.sv
// Shared defaults and index helper for the buffer port arbiter slice.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package buffer_port_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_LEN = 6;
    localparam int DEF_DATA_LEN = 32;

    // Wrap an index that is at most one lap past n back into [0, n).
    // Cheaper than a general modulo, and every caller stays within one lap.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/buffer_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to first requester at or after ptr.
// Latency: grant is combinational in the request cycle; ptr advances on the edge.
// Backpressure: losers simply keep requesting; a held request wins within numReq cycles.
//
// Ports: clk, reset (async, active-high), req[numReq] in;
//        gnt[numReq] one-hot, gnt_idx winner index, gnt_any out.
module rr_arbiter
    import buffer_port_arbiter_pkg::*;
#(
    parameter  int numReq = DEF_NUM_REQ,
    localparam int idLen  = $clog2(numReq)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [numReq-1:0] req,
    output logic [numReq-1:0] gnt,
    output logic [idLen-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [idLen-1:0] ptr;
    logic [idLen-1:0] cand;

    // Scan from ptr upward with wraparound; the first set request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < numReq; k++) begin
            cand = idLen'(rr_wrap(int'(ptr) + k, numReq));
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

    // Winner drops to lowest priority next time; ptr holds while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= idLen'(rr_wrap(int'(gnt_idx) + 1, numReq));
        end
    end

endmodule

// File: rtl/buffer_port_arbiter.sv
// Shares one scratch buffer's write and read ports among numReq requesters.
// Latency: grants combinational (0 cycles); rd_valid/rd_data one cycle after read grant.
// Backpressure: requesters hold req/addr/data until their grant bit is seen high.
//
// Ports: clk, reset (async, active-high);
//        wr_req/wr_addr/wr_data -> wr_gnt; rd_req/rd_addr -> rd_gnt, rd_valid, rd_data;
//        buf_wrt/buf_wrt_addr/buf_data_in, buf_rd_en/buf_rd_addr out, buf_data_out in.
module buffer_port_arbiter
    import buffer_port_arbiter_pkg::*;
#(
    parameter  int numReq  = DEF_NUM_REQ,
    parameter  int addrLen = DEF_ADDR_LEN,
    parameter  int dataLen = DEF_DATA_LEN,
    localparam int idLen   = $clog2(numReq)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [numReq-1:0]         wr_req,
    input  logic [numReq*addrLen-1:0] wr_addr,
    input  logic [numReq*dataLen-1:0] wr_data,
    output logic [numReq-1:0]         wr_gnt,
    input  logic [numReq-1:0]         rd_req,
    input  logic [numReq*addrLen-1:0] rd_addr,
    output logic [numReq-1:0]         rd_gnt,
    output logic [numReq-1:0]         rd_valid,
    output logic [dataLen-1:0]        rd_data,
    output logic                      buf_wrt,
    output logic [addrLen-1:0]        buf_wrt_addr,
    output logic [dataLen-1:0]        buf_data_in,
    output logic                      buf_rd_en,
    output logic [addrLen-1:0]        buf_rd_addr,
    input  logic [dataLen-1:0]        buf_data_out
);

    logic [idLen-1:0] wr_idx;
    logic             wr_any;
    logic [idLen-1:0] rd_idx;
    logic             rd_any;

    // Registered read tag: which requester owns the word coming back next cycle.
    logic [idLen-1:0] rd_tag;
    logic             rd_pend;

    rr_arbiter #(.numReq(numReq)) u_wr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wr_req),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx),
        .gnt_any (wr_any)
    );

    rr_arbiter #(.numReq(numReq)) u_rd_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (rd_req),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx),
        .gnt_any (rd_any)
    );

    // Winner's slices onto the buffer pins; zeros when idle keep the bus quiet.
    always_comb begin
        buf_wrt      = wr_any;
        buf_wrt_addr = '0;
        buf_data_in  = '0;
        if (wr_any) begin
            buf_wrt_addr = wr_addr[int'(wr_idx)*addrLen +: addrLen];
            buf_data_in  = wr_data[int'(wr_idx)*dataLen +: dataLen];
        end
    end

    always_comb begin
        buf_rd_en   = rd_any;
        buf_rd_addr = '0;
        if (rd_any) begin
            buf_rd_addr = rd_addr[int'(rd_idx)*addrLen +: addrLen];
        end
    end

    // rd_pend is cleared every idle cycle so a stale tag is never flagged;
    // the async reset drops any in-flight result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_tag  <= '0;
        end else begin
            rd_pend <= rd_any;
            if (rd_any) begin
                rd_tag <= rd_idx;
            end
        end
    end

    // One-hot decode of the registered tag; only flop outputs feed it.
    always_comb begin
        rd_valid = '0;
        if (rd_pend) begin
            rd_valid[rd_tag] = 1'b1;
        end
    end

    // Buffer holds data_out when not read; no masking here.
    assign rd_data = buf_data_out;

endmodule
